// File: rtl/sd_tx_bd_queue_if.sv
// Host / data-master bus of the SD buffer-descriptor queue.
// The master modport is the user side (host writes, master reads); the slave modport is the queue.
interface sd_tx_bd_queue_if #(
    parameter int MEM_WIDTH = 32,
    parameter int BD_WIDTH  = 8
);
    logic                 we_m;
    logic [MEM_WIDTH-1:0] dat_in_m;
    logic                 new_bw;
    logic [BD_WIDTH-1:0]  free_bd;
    logic                 re_s;
    logic                 ack_o_s;
    logic [MEM_WIDTH-1:0] dat_out_s;
    logic                 a_cmp;
    logic                 ovf_err;
    logic                 unf_err;
    logic                 err_clr;

    modport master (
        output we_m, dat_in_m, re_s, a_cmp, err_clr,
        input  new_bw, free_bd, ack_o_s, dat_out_s, ovf_err, unf_err
    );

    modport slave (
        input  we_m, dat_in_m, re_s, a_cmp, err_clr,
        output new_bw, free_bd, ack_o_s, dat_out_s, ovf_err, unf_err
    );
endinterface

// File: rtl/sd_tx_bd_queue.sv
// Circular buffer-descriptor queue: host commits READ_CYCLE-word BDs, the data master
// reads the oldest BD word by word and releases it with a_cmp.
module sd_tx_bd_queue #(
    parameter int MEM_WIDTH  = 32,
    parameter int BD_SIZE    = 16,
    parameter int BD_WIDTH   = 8,
    parameter int READ_CYCLE = 2
) (
    input  logic            clk,
    input  logic            rst,
    sd_tx_bd_queue_if.slave bus
);
    localparam int AW       = $clog2(BD_SIZE);
    localparam int WW       = $clog2(READ_CYCLE + 1);
    localparam int BD_EMPTY = BD_SIZE / READ_CYCLE;

    localparam logic [BD_WIDTH-1:0] FREE_MAX  = BD_WIDTH'(BD_EMPTY);
    localparam logic [BD_WIDTH-1:0] FREE_ONE  = BD_WIDTH'(1);
    localparam logic [WW-1:0]       LAST_WORD = WW'(READ_CYCLE - 1);
    localparam logic [WW-1:0]       WORDS     = WW'(READ_CYCLE);
    localparam logic [WW-1:0]       WORD_ONE  = WW'(1);
    localparam logic [AW-1:0]       ADDR_ONE  = AW'(1);
    localparam logic [AW-1:0]       BD_STRIDE = AW'(READ_CYCLE);

    logic [MEM_WIDTH-1:0] ram [BD_SIZE];

    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_base;
    logic [WW-1:0] wr_word;
    logic [WW-1:0] rd_word;
    logic          re_s_q;

    logic          q_empty;
    logic          q_full;
    logic          wr_ok;
    logic          commit;
    logic          release_bd;
    logic          rd_start;
    logic          rd_fire;
    logic [WW-1:0] rd_word_eff;
    logic [AW-1:0] rd_addr;

    // NOTE: every signal here is assigned on every pass, so no latch can be inferred.
    always_comb begin
        q_empty     = (bus.free_bd == FREE_MAX);
        q_full      = (bus.free_bd == '0);
        wr_ok       = bus.we_m && !q_full;
        commit      = wr_ok && (wr_word == LAST_WORD);
        release_bd  = bus.a_cmp && !q_empty;
        rd_start    = bus.re_s && !re_s_q;
        rd_word_eff = rd_start ? '0 : rd_word;
        // A release cycle does not deliver a word: the head BD is being retired.
        rd_fire     = bus.re_s && !q_empty && !release_bd && (rd_word_eff < WORDS);
        rd_addr     = rd_base + AW'(rd_word_eff);
    end

    // NOTE: the RAM is deliberately not reset; its words are only observable after a commit.
    always_ff @(posedge clk) begin
        if (wr_ok) begin
            ram[wr_ptr] <= bus.dat_in_m;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers sample pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr        <= '0;
            wr_word       <= '0;
            rd_base       <= '0;
            rd_word       <= '0;
            re_s_q        <= 1'b0;
            bus.free_bd   <= FREE_MAX;
            bus.new_bw    <= 1'b0;
            bus.ack_o_s   <= 1'b0;
            bus.dat_out_s <= '0;
            bus.ovf_err   <= 1'b0;
            bus.unf_err   <= 1'b0;
        end else begin
            re_s_q     <= bus.re_s;
            bus.new_bw <= commit;

            if (wr_ok) begin
                wr_ptr  <= wr_ptr + ADDR_ONE;
                wr_word <= commit ? '0 : wr_word + WORD_ONE;
            end

            if (commit && !release_bd) begin
                bus.free_bd <= bus.free_bd - FREE_ONE;
            end else if (release_bd && !commit) begin
                bus.free_bd <= bus.free_bd + FREE_ONE;
            end

            bus.ack_o_s <= rd_fire;
            if (rd_fire) begin
                bus.dat_out_s <= ram[rd_addr];
            end

            if (release_bd) begin
                rd_base <= rd_base + BD_STRIDE;
                rd_word <= '0;
            end else if (rd_fire) begin
                rd_word <= rd_word_eff + WORD_ONE;
            end else begin
                rd_word <= rd_word_eff;
            end

            // A same-cycle set beats err_clr.
            if (bus.we_m && q_full) begin
                bus.ovf_err <= 1'b1;
            end else if (bus.err_clr) begin
                bus.ovf_err <= 1'b0;
            end

            if (bus.a_cmp && q_empty) begin
                bus.unf_err <= 1'b1;
            end else if (bus.err_clr) begin
                bus.unf_err <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_sd_tx_bd_queue.sv
// Self-checking bench for sd_tx_bd_queue: directed scenarios with literal expectations plus
// randomized traffic compared every cycle against a queue-of-words reference model.
module tb_sd_tx_bd_queue;
    localparam int BD_EMPTY = 8;
    localparam int RC       = 2;

    logic clk;
    logic rst;
    bit   chk_en;
    int   n_checks;
    int   n_errors;

    sd_tx_bd_queue_if #(.MEM_WIDTH(32), .BD_WIDTH(8)) bus ();

    sd_tx_bd_queue #(
        .MEM_WIDTH (32),
        .BD_SIZE   (16),
        .BD_WIDTH  (8),
        .READ_CYCLE(RC)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: committed BDs as a flat FIFO of words, the partial BD held separately.
    logic [31:0] bd_q[$];
    logic [31:0] part_q[$];
    int          rd_cnt;
    bit          prev_re;
    bit          m_ack;
    bit          m_new_bw;
    bit          m_ovf;
    bit          m_unf;
    logic [31:0] m_dat;
    bit          m_nonempty;
    bit          m_commit;
    bit          m_release;
    bit          m_ovf_set;
    bit          m_unf_set;
    int          m_cnt;

    function automatic int m_free();
        return BD_EMPTY - bd_q.size() / RC;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            bd_q.delete();
            part_q.delete();
            rd_cnt   = 0;
            prev_re  = 1'b0;
            m_ack    = 1'b0;
            m_new_bw = 1'b0;
            m_ovf    = 1'b0;
            m_unf    = 1'b0;
            m_dat    = '0;
        end else begin
            m_nonempty = (bd_q.size() != 0);
            m_commit   = 1'b0;
            m_ovf_set  = 1'b0;
            if (bus.we_m) begin
                if (m_free() != 0) begin
                    part_q.push_back(bus.dat_in_m);
                    m_commit = (part_q.size() == RC);
                end else begin
                    m_ovf_set = 1'b1;
                end
            end
            m_release = bus.a_cmp && m_nonempty;
            m_unf_set = bus.a_cmp && !m_nonempty;

            m_cnt = (bus.re_s && !prev_re) ? 0 : rd_cnt;
            if (bus.re_s && m_nonempty && !m_release && m_cnt < RC) begin
                m_ack  = 1'b1;
                m_dat  = bd_q[m_cnt];
                rd_cnt = m_cnt + 1;
            end else begin
                m_ack  = 1'b0;
                rd_cnt = m_cnt;
            end
            if (m_release) begin
                for (int i = 0; i < RC; i++) void'(bd_q.pop_front());
                rd_cnt = 0;
            end
            if (m_commit) begin
                while (part_q.size() != 0) bd_q.push_back(part_q.pop_front());
            end
            m_new_bw = m_commit;
            if (m_ovf_set) m_ovf = 1'b1; else if (bus.err_clr) m_ovf = 1'b0;
            if (m_unf_set) m_unf = 1'b1; else if (bus.err_clr) m_unf = 1'b0;
            prev_re = bus.re_s;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("free_bd", {24'd0, bus.free_bd}, m_free());
            check("new_bw", {31'd0, bus.new_bw}, {31'd0, m_new_bw});
            check("ack_o_s", {31'd0, bus.ack_o_s}, {31'd0, m_ack});
            check("dat_out_s", bus.dat_out_s, m_dat);
            check("ovf_err", {31'd0, bus.ovf_err}, {31'd0, m_ovf});
            check("unf_err", {31'd0, bus.unf_err}, {31'd0, m_unf});
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_bd(input logic [31:0] w0, input logic [31:0] w1);
        bus.we_m     = 1'b1;
        bus.dat_in_m = w0;
        tick();
        bus.dat_in_m = w1;
        tick();
        bus.we_m     = 1'b0;
    endtask

    task automatic read_bd(output logic [31:0] w0, output logic [31:0] w1);
        int got;
        got = 0;
        w0  = '0;
        w1  = '0;
        bus.re_s = 1'b1;
        for (int i = 0; i < 8 && got < RC; i++) begin
            tick();
            if (bus.ack_o_s) begin
                if (got == 0) w0 = bus.dat_out_s; else w1 = bus.dat_out_s;
                got++;
            end
        end
        bus.re_s = 1'b0;
        tick();
        check("read_acks", got, RC);
    endtask

    task automatic release_bd();
        bus.a_cmp = 1'b1;
        tick();
        bus.a_cmp = 1'b0;
    endtask

    logic [31:0] r0, r1;
    logic [31:0] exp_w[16];

    initial begin
        n_checks = 0;
        n_errors = 0;
        chk_en   = 1'b0;
        rst      = 1'b1;
        bus.we_m = 1'b0; bus.dat_in_m = '0; bus.re_s = 1'b0;
        bus.a_cmp = 1'b0; bus.err_clr = 1'b0;
        tick();
        chk_en = 1'b1;
        tick();
        rst = 1'b0;
        check("rst_free_bd", {24'd0, bus.free_bd}, 8);
        check("rst_ack", {31'd0, bus.ack_o_s}, 0);
        check("rst_dat", bus.dat_out_s, 0);

        // One BD commit.
        write_bd(32'h1000_0000, 32'h0000_0200);
        check("commit_new_bw", {31'd0, bus.new_bw}, 1);
        check("commit_free_bd", {24'd0, bus.free_bd}, 7);
        tick();
        check("new_bw_single", {31'd0, bus.new_bw}, 0);

        // Hold re_s for three cycles: exactly two acks.
        bus.re_s = 1'b1;
        tick();
        check("ack0", {31'd0, bus.ack_o_s}, 1);
        check("ack0_dat", bus.dat_out_s, 32'h1000_0000);
        tick();
        check("ack1", {31'd0, bus.ack_o_s}, 1);
        check("ack1_dat", bus.dat_out_s, 32'h0000_0200);
        tick();
        check("no_third_ack", {31'd0, bus.ack_o_s}, 0);
        bus.re_s = 1'b0;
        release_bd();
        check("release_free_bd", {24'd0, bus.free_bd}, 8);

        // Fill completely, then one extra word.
        bus.we_m = 1'b1;
        for (int i = 0; i < 16; i++) begin
            bus.dat_in_m = 32'hA000_0000 + i;
            tick();
        end
        check("full_free_bd", {24'd0, bus.free_bd}, 0);
        bus.dat_in_m = 32'hDEAD_BEEF;
        tick();
        bus.we_m = 1'b0;
        check("ovf_set", {31'd0, bus.ovf_err}, 1);
        check("ovf_free_bd", {24'd0, bus.free_bd}, 0);

        // Read first BD, drop re_s without a_cmp, read again: same words.
        read_bd(r0, r1);
        check("first_w0", r0, 32'hA000_0000);
        check("first_w1", r1, 32'hA000_0001);
        read_bd(r0, r1);
        check("retry_w0", r0, 32'hA000_0000);
        check("retry_w1", r1, 32'hA000_0001);
        release_bd();
        for (int b = 1; b < 8; b++) begin
            read_bd(r0, r1);
            check("drain_w0", r0, 32'hA000_0000 + 2 * b);
            check("drain_w1", r1, 32'hA000_0001 + 2 * b);
            release_bd();
        end
        check("drained_free_bd", {24'd0, bus.free_bd}, 8);

        // Commit coinciding with a_cmp.
        write_bd(32'hB000_0000, 32'hB000_0001);
        bus.we_m = 1'b1; bus.dat_in_m = 32'hC000_0000;
        tick();
        bus.dat_in_m = 32'hC000_0001; bus.a_cmp = 1'b1;
        tick();
        bus.we_m = 1'b0; bus.a_cmp = 1'b0;
        check("coincide_free_bd", {24'd0, bus.free_bd}, 7);
        check("coincide_new_bw", {31'd0, bus.new_bw}, 1);
        read_bd(r0, r1);
        check("order_w0", r0, 32'hC000_0000);
        check("order_w1", r1, 32'hC000_0001);
        release_bd();

        // Fill and drain three times so the pointers wrap.
        for (int r = 0; r < 3; r++) begin
            for (int b = 0; b < 8; b++) begin
                exp_w[2*b]   = $urandom();
                exp_w[2*b+1] = $urandom();
                write_bd(exp_w[2*b], exp_w[2*b+1]);
            end
            for (int b = 0; b < 8; b++) begin
                read_bd(r0, r1);
                check("wrap_w0", r0, exp_w[2*b]);
                check("wrap_w1", r1, exp_w[2*b+1]);
                release_bd();
            end
        end

        // Underflow, clear, and set-beats-clear.
        release_bd();
        check("unf_set", {31'd0, bus.unf_err}, 1);
        check("unf_free_bd", {24'd0, bus.free_bd}, 8);
        bus.err_clr = 1'b1;
        tick();
        bus.err_clr = 1'b0;
        check("unf_clr", {31'd0, bus.unf_err}, 0);
        check("ovf_clr", {31'd0, bus.ovf_err}, 0);
        bus.a_cmp = 1'b1; bus.err_clr = 1'b1;
        tick();
        bus.a_cmp = 1'b0; bus.err_clr = 1'b0;
        check("set_beats_clr", {31'd0, bus.unf_err}, 1);

        // Reset in the middle of a read.
        write_bd(32'h5555_0000, 32'h5555_0001);
        bus.re_s = 1'b1;
        tick();
        check("pre_rst_ack", {31'd0, bus.ack_o_s}, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0; bus.re_s = 1'b0;
        check("mid_rst_ack", {31'd0, bus.ack_o_s}, 0);
        check("mid_rst_free_bd", {24'd0, bus.free_bd}, 8);
        tick();

        // Randomized traffic against the model.
        for (int c = 0; c < 3000; c++) begin
            bus.we_m     = ($urandom_range(0, 99) < 45);
            bus.dat_in_m = $urandom();
            if ($urandom_range(0, 99) < 20) bus.re_s = !bus.re_s;
            bus.a_cmp    = ($urandom_range(0, 99) < 12);
            bus.err_clr  = ($urandom_range(0, 99) < 5);
            rst          = ($urandom_range(0, 999) < 3);
            tick();
        end
        bus.we_m = 1'b0; bus.re_s = 1'b0; bus.a_cmp = 1'b0; bus.err_clr = 1'b0; rst = 1'b0;
        tick();
        tick();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
